// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-memory port between the I-cache refill
// path and the D-cache refill/writeback path, with I-side refill abort.
module mem_arbiter #(
    parameter int LINE_W = 512,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              iabort,
    output logic              iready,
    output logic [LINE_W-1:0] irdata,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [LINE_W-1:0] dwdata,
    output logic              dready,
    output logic [LINE_W-1:0] drdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_abort,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-6){1'b1}}, 6'b000000};

    state_t state_r;
    logic   last_grant_d_r;
    logic   ireq_live_s;
    logic   grant_i_s;
    logic   grant_d_s;

    // Grant decision in IDLE: a tie goes to the side that did not win last time.
    always_comb begin
        ireq_live_s = ireq & ~iabort;
        grant_i_s   = 1'b0;
        grant_d_s   = 1'b0;
        if (state_r == IDLE) begin
            if (ireq_live_s && dreq) begin
                grant_i_s = last_grant_d_r;
                grant_d_s = ~last_grant_d_r;
            end else begin
                grant_i_s = ireq_live_s;
                grant_d_s = dreq;
            end
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Transaction FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            last_grant_d_r <= 1'b1;
            iready         <= 1'b0;
            dready         <= 1'b0;
            irdata         <= '0;
            drdata         <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_abort      <= 1'b0;
        end else begin
            iready    <= 1'b0;
            dready    <= 1'b0;
            mem_abort <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_i_s) begin
                        mem_req        <= 1'b1;
                        mem_we         <= 1'b0;
                        mem_addr       <= iaddr & LINE_MASK;
                        mem_wdata      <= '0;
                        last_grant_d_r <= 1'b0;
                        state_r        <= BUSY_I;
                    end else if (grant_d_s) begin
                        mem_req        <= 1'b1;
                        mem_we         <= dwe;
                        mem_addr       <= daddr & LINE_MASK;
                        mem_wdata      <= dwdata;
                        last_grant_d_r <= 1'b1;
                        state_r        <= BUSY_D;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I: begin
                    // A redirect beats a same-edge completion; that line is dropped.
                    if (iabort) begin
                        mem_abort <= 1'b1;
                        mem_req   <= 1'b0;
                        state_r   <= IDLE;
                    end else if (mem_ready) begin
                        irdata  <= mem_rdata;
                        iready  <= 1'b1;
                        mem_req <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        state_r <= BUSY_I;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            drdata <= mem_rdata;
                        end else begin
                            drdata <= drdata;
                        end
                        dready  <= 1'b1;
                        mem_req <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        state_r <= BUSY_D;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural line memory, scoreboard
// queues for grants and returned lines, vector table plus corner sequences.
module tb_mem_arbiter;

    localparam int LW = 512;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ireq = 1'b0;
    logic          iabort = 1'b0;
    logic [AW-1:0] iaddr = '0;
    logic          dreq = 1'b0;
    logic          dwe = 1'b0;
    logic [AW-1:0] daddr = '0;
    logic [LW-1:0] dwdata = '0;
    logic          mem_ready = 1'b0;
    logic [LW-1:0] mem_rdata = '0;
    logic          iready, dready, mem_req, mem_we, mem_abort;
    logic [LW-1:0] irdata, drdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } grant_t;

    typedef struct {
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        int            lat;
        logic [AW-1:0] exp_addr;
    } vec_t;

    grant_t        gq[$];
    logic [LW-1:0] iq[$];
    logic [LW-1:0] dq[$];
    int            gcyc[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            lat = 4;
    int            mcnt = 0;
    int            abort_cnt = 0;
    logic          prev_req = 1'b0, prev_ir = 1'b0, prev_dr = 1'b0, prev_ab = 1'b0;
    logic [LW-1:0] d_shadow = '0;
    logic [LW-1:0] i_shadow = '0;

    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .iabort(iabort), .iready(iready), .irdata(irdata),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dready(dready), .drdata(drdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_abort(mem_abort), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {16{a ^ 32'h3C5A_0F96}};
    endfunction

    task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_i(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s got=unexpected exp=none", name);
    endtask

    // Line memory: mem_ready arrives lat cycles after mem_req rises.
    always @(negedge clk) begin
        if (!mem_req) begin
            mcnt      = 0;
            mem_ready = 1'b0;
            mem_rdata = ~mem_rdata;
        end else begin
            mcnt      = mcnt + 1;
            mem_ready = (mcnt == lat + 1);
            mem_rdata = mem_ready ? line_of(mem_addr) : ~line_of(mem_addr);
        end
    end

    // Monitor: pops scoreboard entries as grants and ready pulses appear.
    always @(negedge clk) begin : mon
        grant_t g;
        if (reset) begin
            prev_req = 1'b0; prev_ir = 1'b0; prev_dr = 1'b0; prev_ab = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                gcyc.push_back(cyc);
                if (gq.size() == 0) begin
                    flag("grant_unexpected");
                end else begin
                    g = gq.pop_front();
                    check_i("grant_we", int'(mem_we), int'(g.we));
                    check_i("grant_addr", int'(mem_addr), int'(g.addr));
                    if (g.we) check("grant_wdata", mem_wdata, g.wdata);
                end
            end
            if (iready) begin
                if (prev_ir) flag("iready_width");
                else if (iq.size() == 0) flag("iready_unexpected");
                else check("irdata", irdata, iq.pop_front());
            end
            if (dready) begin
                if (prev_dr) flag("dready_width");
                else if (dq.size() == 0) flag("dready_unexpected");
                else check("drdata", drdata, dq.pop_front());
            end
            if (mem_abort) begin
                abort_cnt++;
                check_i("abort_req_low", int'(mem_req), 0);
                if (prev_ab) flag("abort_width");
            end
            prev_req = mem_req; prev_ir = iready; prev_dr = dready; prev_ab = mem_abort;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input bit is_d, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (is_d ? dready : iready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_i({tag, "_ctrl"}, int'({iready, dready, mem_req, mem_we, mem_abort}), 0);
        check_i({tag, "_addr"}, int'(mem_addr), 0);
        check({tag, "_wdata"}, mem_wdata, '0);
        check({tag, "_irdata"}, irdata, '0);
        check({tag, "_drdata"}, drdata, '0);
    endtask

    // Both sides request back to back; n transactions alternate starting with I.
    task automatic run_both(input int n, input logic [AW-1:0] ibase, input logic [AW-1:0] dbase);
        int   done_n = 0;
        int   ii = 0;
        int   di = 0;
        int   first_ready = -1;
        bit   re_i = 1'b0;
        bit   re_d = 1'b0;
        logic [AW-1:0] a;
        gcyc.delete();
        for (int k = 0; k < n; k++) begin
            if (k % 2 == 0) begin
                a = (ibase + 32'(k / 2 * 64)) & 32'hFFFF_FFC0;
                gq.push_back('{we: 1'b0, addr: a, wdata: '0});
                iq.push_back(line_of(a));
                i_shadow = line_of(a);
            end else begin
                a = (dbase + 32'(k / 2 * 64)) & 32'hFFFF_FFC0;
                gq.push_back('{we: 1'b0, addr: a, wdata: '0});
                dq.push_back(line_of(a));
                d_shadow = line_of(a);
            end
        end
        lat = 3;
        dwe = 1'b0;
        iaddr = ibase + 32'd5;
        daddr = dbase + 32'd9;
        ireq = 1'b1;
        dreq = 1'b1;
        for (int c = 0; c < 2000 && done_n < n; c++) begin
            @(negedge clk);
            if (re_i) begin ireq = 1'b1; re_i = 1'b0; end
            if (re_d) begin dreq = 1'b1; re_d = 1'b0; end
            if (iready) begin
                if (first_ready < 0) first_ready = cyc;
                done_n++; ii++;
                ireq = 1'b0;
                iaddr = ibase + 32'(ii * 64) + 32'd5;
                re_i = (ii < n / 2);
            end
            if (dready) begin
                if (first_ready < 0) first_ready = cyc;
                done_n++; di++;
                dreq = 1'b0;
                daddr = dbase + 32'(di * 64) + 32'd9;
                re_d = (di < n / 2);
            end
        end
        ireq = 1'b0;
        dreq = 1'b0;
        check_i("both_count", done_n, n);
        if (gcyc.size() >= 2) check_i("regrant_gap", gcyc[1] - first_ready, 2);
        else flag("regrant_missing");
        tick(2);
    endtask

    vec_t          vt[5];
    bit            ok;
    int            t0;
    int            g0;
    int            ab0;
    logic [LW-1:0] e;

    initial begin
        vt[0] = '{is_d: 1'b0, we: 1'b0, addr: 32'h0000_0047, wdata: '0,              lat: 20, exp_addr: 32'h0000_0040};
        vt[1] = '{is_d: 1'b1, we: 1'b1, addr: 32'h0000_01FC, wdata: {64{8'hA5}},     lat: 5,  exp_addr: 32'h0000_01C0};
        vt[2] = '{is_d: 1'b1, we: 1'b0, addr: 32'h1234_5678, wdata: '0,              lat: 3,  exp_addr: 32'h1234_5640};
        vt[3] = '{is_d: 1'b0, we: 1'b0, addr: 32'hFFFF_FFFF, wdata: '0,              lat: 1,  exp_addr: 32'hFFFF_FFC0};
        vt[4] = '{is_d: 1'b1, we: 1'b1, addr: 32'h0000_003F, wdata: {16{32'hDEAD_BEEF}}, lat: 0, exp_addr: 32'h0000_0000};

        tick(2);
        check_all_zero("reset");
        reset = 1'b0;
        tick(1);

        for (int k = 0; k < 5; k++) begin
            lat = vt[k].lat;
            gq.push_back('{we: vt[k].we, addr: vt[k].exp_addr, wdata: vt[k].wdata});
            if (vt[k].is_d) begin
                e = vt[k].we ? d_shadow : line_of(vt[k].exp_addr);
                dq.push_back(e);
                d_shadow = e;
                dwe = vt[k].we; daddr = vt[k].addr; dwdata = vt[k].wdata;
                dreq = 1'b1;
            end else begin
                e = line_of(vt[k].exp_addr);
                iq.push_back(e);
                i_shadow = e;
                iaddr = vt[k].addr;
                ireq = 1'b1;
            end
            t0 = cyc;
            wait_ready(vt[k].is_d, ok);
            check_i("vec_done", int'(ok), 1);
            check_i("vec_latency", cyc - t0, vt[k].lat + 2);
            ireq = 1'b0;
            dreq = 1'b0;
            tick(2);
        end

        // Simultaneous requests from reset, then continuous alternation.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        d_shadow = '0;
        i_shadow = '0;
        run_both(4, 32'h0000_1000, 32'h0000_1800);

        // I abort in the fifth busy cycle while a D read waits.
        lat = 30;
        gcyc.delete();
        ab0 = abort_cnt;
        gq.push_back('{we: 1'b0, addr: 32'h0000_2000, wdata: '0});
        iaddr = 32'h0000_2003;
        ireq = 1'b1;
        g0 = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_req) begin g0 = cyc; break; end
        end
        check_i("abort_granted", int'(g0 >= 0), 1);
        gq.push_back('{we: 1'b0, addr: 32'h0000_3000, wdata: '0});
        dq.push_back(line_of(32'h0000_3000));
        d_shadow = line_of(32'h0000_3000);
        daddr = 32'h0000_3010;
        dwe = 1'b0;
        dreq = 1'b1;
        tick(4);
        iabort = 1'b1;
        tick(1);
        check_i("abort_pulse", int'(mem_abort), 1);
        check_i("abort_mem_req", int'(mem_req), 0);
        t0 = cyc;
        ireq = 1'b0;
        iabort = 1'b0;
        lat = 4;
        wait_ready(1'b1, ok);
        check_i("abort_then_d", int'(ok), 1);
        dreq = 1'b0;
        if (gcyc.size() >= 2) check_i("abort_d_grant", gcyc[1] - t0, 1);
        else flag("abort_d_grant_missing");
        check_i("abort_count", abort_cnt - ab0, 1);
        tick(2);

        // Abort on the same edge as mem_ready: data is discarded.
        lat = 6;
        ab0 = abort_cnt;
        gq.push_back('{we: 1'b0, addr: 32'h0000_4000, wdata: '0});
        iaddr = 32'h0000_4020;
        ireq = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (mem_ready) begin ok = 1'b1; break; end
        end
        check_i("coinc_mem_ready", int'(ok), 1);
        iabort = 1'b1;
        tick(1);
        check_i("coinc_abort", int'(mem_abort), 1);
        ireq = 1'b0;
        iabort = 1'b0;
        tick(4);
        check("coinc_irdata_held", irdata, i_shadow);
        check_i("coinc_abort_count", abort_cnt - ab0, 1);

        // iabort during a D transaction has no effect.
        lat = 8;
        ab0 = abort_cnt;
        gq.push_back('{we: 1'b0, addr: 32'h0000_5000, wdata: '0});
        dq.push_back(line_of(32'h0000_5000));
        d_shadow = line_of(32'h0000_5000);
        daddr = 32'h0000_5004;
        dwe = 1'b0;
        dreq = 1'b1;
        tick(3);
        iabort = 1'b1;
        wait_ready(1'b1, ok);
        check_i("dabort_ready", int'(ok), 1);
        dreq = 1'b0;
        tick(1);
        iabort = 1'b0;
        check_i("dabort_no_abort", abort_cnt - ab0, 0);
        tick(2);

        // Reset in the middle of a D writeback.
        lat = 40;
        gq.push_back('{we: 1'b1, addr: 32'h0000_6000, wdata: {64{8'h3C}}});
        daddr = 32'h0000_6008;
        dwe = 1'b1;
        dwdata = {64{8'h3C}};
        dreq = 1'b1;
        tick(6);
        check_i("midrst_busy", int'(mem_req), 1);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        tick(1);
        dreq = 1'b0;
        dwe = 1'b0;
        reset = 1'b0;
        d_shadow = '0;
        i_shadow = '0;
        run_both(2, 32'h0000_7000, 32'h0000_8000);

        tick(5);
        check_i("queues_empty", gq.size() + iq.size() + dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single slow backing-memory line port between the instruction-cache refill path and the data-cache refill/writeback path.
- Arbitrates round-robin between the two, aligns addresses to 64-byte lines, tracks the outstanding transaction and routes the returned line and ready pulse to the owner.
- Supports aborting an instruction refill on a taken branch or jump.
- Sits between i_cache/d_cache and the shared line memory.

Parameters:
- LINE_W, 512: line width in bits (16 words).
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ireq  in  1  I-side refill request; held until iready or iabort
- iaddr  in  ADDR_W  I-side byte address
- iabort  in  1  cancel pending I-side refill (branch/jump redirect)
- iready  out  1  one-cycle pulse: irdata valid
- irdata  out  LINE_W  returned I-side line
- dreq  in  1  D-side request; held until dready
- dwe  in  1  D-side write (writeback) when 1, refill when 0
- daddr  in  ADDR_W  D-side byte address
- dwdata  in  LINE_W  D-side writeback line
- dready  out  1  one-cycle pulse: D transaction complete, drdata valid on reads
- drdata  out  LINE_W  returned D-side line
- mem_req  out  1  memory transaction active
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  line address, low 6 bits zero
- mem_wdata  out  LINE_W  write line
- mem_abort  out  1  one-cycle pulse: memory drops the current transaction and resets its delay count
- mem_ready  in  1  one-cycle completion pulse from memory
- mem_rdata  in  LINE_W  read line, valid with mem_ready

Behaviour:
- Clock and reset: clock is clk; reset is asynchronous, active-high.
- Reset values:
  - state IDLE; last_grant = D, so I wins the first tie.
  - All outputs 0, including iready, dready, irdata, drdata, mem_*.
- States:
  - IDLE, BUSY_I, BUSY_D, DONE.
  - All transitions occur on the rising clk edge.
- IDLE:
  - Only ireq (not iabort): go BUSY_I.
  - Only dreq: go BUSY_D.
  - Both requesting: grant the side that is not last_grant, then update last_grant.
  - On grant, register address {addr[31:6],6'b0}, the we bit (0 for I) and wdata into the mem_* outputs; mem_req = 1 from the next cycle.
  - ireq together with iabort in IDLE: ignored.
- BUSY_x:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - When mem_ready = 1 is sampled: latch mem_rdata into the owner's rdata (reads only; writes leave drdata unchanged), assert the owner's ready for exactly one cycle, drop mem_req, go DONE.
- DONE:
  - Lasts one cycle; the requester deasserts req in this cycle.
  - No grant is made in DONE, which prevents re-grant of a stale req. Then go IDLE.
- Latency: the grant edge follows the req cycle, and ready rises one cycle after mem_ready. Round trip = memory latency + 2 cycles.
- I abort:
  - iabort = 1 in BUSY_I: mem_abort pulses one cycle, mem_req drops, no iready, go IDLE.
  - Abort wins over a mem_ready sampled on the same edge; the data is discarded.
  - iabort is ignored in BUSY_D and DONE.
  - D transactions are never aborted.
- mem_ready outside BUSY_x: ignored.
- Outputs: irdata and drdata hold their last value between transactions.
- Reset mid-transaction: returns to IDLE immediately, all pulses cleared, last_grant = D.
- Starvation bound: with both sides requesting continuously, grants alternate I, D, I, D.

Test Plan:
- Single I refill: after reset, ireq = 1, iaddr = 0x0000_0047, memory latency 20 → mem_addr = 0x0000_0040, mem_we = 0; iready pulses exactly one cycle, 22 cycles after ireq rises, with irdata = memory line; no dready.
- D writeback: dreq = 1, dwe = 1, daddr = 0x0000_01FC, dwdata = pattern A5.. → mem_addr = 0x0000_01C0, mem_we = 1, mem_wdata = pattern; dready pulses once; drdata unchanged.
- Simultaneous requests: ireq and dreq both rise in the same cycle from reset → I granted first, D granted on the first IDLE after DONE. Repeat with both held continuously → grant order I, D, I, D.
- Abort:
  - iabort at cycle 5 of BUSY_I → mem_abort pulses one cycle, mem_req = 0 next cycle, no iready; a pending dreq is granted next.
  - iabort coincident with mem_ready → no iready.
- Abort during D: iabort while BUSY_D → no effect; dready still pulses.
- Reset mid-operation: reset asserted while BUSY_D → all outputs 0 immediately; after release, a simultaneous I and D request grants I first.
